// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed little-endian data memory with RV32I
// load/store sizing, access checking and a fixed-latency response pipe.
// A zeroing sweep runs after every reset before requests are taken.
module data_memory_lsu #(
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WIDX  = AW - 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [WIDX-1:0]                     clr_cnt_q, clr_cnt_d;
    logic [READ_LATENCY-1:0]             vld_q, vld_d;
    logic [READ_LATENCY-1:0]             err_q, err_d;
    logic [READ_LATENCY-1:0][31:0]       rdata_q, rdata_d;

    logic [31:0] mem [WORDS];

    logic            acc;
    logic            size_b, size_h, size_w;
    logic            illegal, misalign, out_range, err;
    logic [WIDX-1:0] widx;
    logic [31:0]     rd_word, rd_shift, ld_data;
    logic            mem_we;
    logic [WIDX-1:0] mem_widx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;

    assign req_ready = (state_q == S_READY);
    assign acc       = req_valid && req_ready && resetn;
    assign widx      = req_addr[AW-1:2];

    // Request decode: size, legality, alignment and range checks.
    always_comb begin
        size_b    = (req_funct3[1:0] == 2'b00);
        size_h    = (req_funct3[1:0] == 2'b01);
        size_w    = (req_funct3[1:0] == 2'b10);
        if (req_we)
            illegal = (req_funct3 > 3'd2);
        else
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        misalign  = (size_h && req_addr[0]) || (size_w && (req_addr[1:0] != 2'b00));
        out_range = |req_addr[31:AW];
        err       = illegal || misalign || out_range;
    end

    // Load path: pick the addressed lanes out of the word and extend.
    always_comb begin
        rd_word  = mem[widx];
        rd_shift = rd_word >> {req_addr[1:0], 3'b000};
        case (req_funct3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_data = {16'h0, rd_shift[15:0]};
            3'b010:  ld_data = rd_shift;
            default: ld_data = 32'h0;
        endcase
    end

    // Array write port: clear sweep owns it in CLEAR, legal stores in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = widx;
        mem_be    = 4'h0;
        mem_wdata = req_wdata << {req_addr[1:0], 3'b000};
        if (state_q == S_CLEAR) begin
            mem_we    = resetn;
            mem_widx  = clr_cnt_q;
            mem_be    = 4'hf;
            mem_wdata = 32'h0;
        end else if (acc && req_we && !err) begin
            mem_we = 1'b1;
            if (size_b)
                mem_be = 4'b0001 << req_addr[1:0];
            else if (size_h)
                mem_be = 4'b0011 << req_addr[1:0];
            else
                mem_be = 4'b1111;
        end
    end

    // Byte-enabled storage; contents are defined only after the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b])
                    mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Next state: sweep one word per cycle, then stay ready.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == WIDX'(WORDS - 1))
                state_d = S_READY;
        end
    end

    // Response pipe: stage 0 captures at acceptance, later stages shift.
    always_comb begin
        vld_d      = '0;
        err_d      = '0;
        rdata_d    = '0;
        vld_d[0]   = acc;
        err_d[0]   = acc && err;
        rdata_d[0] = (acc && !req_we && !err) ? ld_data : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    // State and pipe registers; reset drops all in-flight responses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            vld_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rsp_valid = vld_q[READ_LATENCY-1];
    assign rsp_err   = err_q[READ_LATENCY-1];
    assign rsp_rdata = rdata_q[READ_LATENCY-1];

endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Parametrised, byte-addressed, little-endian data memory for the single-cycle RISC-V core, sitting behind the execute stage's load/store path. It decodes RV32I load/store size from `funct3`, applies byte enables on stores and sign/zero extension on loads, and flags misaligned, out-of-range or illegal accesses. Requests use a valid/ready handshake with a configurable, fully pipelined response latency. After reset, a sequential clear sweep zeroes the array.

## Interface
- `DEPTH_BYTES`, 4096: memory size in bytes; power of two, ≥ 8, multiple of 4.
- `READ_LATENCY`, 1: response latency in cycles, legal range 1..4.
- `clk`  in  1  clock, all state on rising edge.
- `resetn`  in  1  reset, synchronous, active-low; clock clk.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_wdata`  in  32  store data, right-aligned (rs2).
- `rsp_valid`  out  1  response present; one-cycle pulse per accepted request.
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err`  out  1  accepted request was misaligned, out of range or illegal.

## Operation
- Storage is `DEPTH_BYTES/4` 32-bit words with per-byte write enables. Word index is `req_addr[log2(DEPTH_BYTES)-1:2]`.
- FSM states:
  - CLEAR: entered on every cycle with `resetn`=0. On exit from reset, a word counter writes 0 to words 0..`DEPTH_BYTES/4`-1, one word per cycle. `req_ready`=0.
  - READY: entered after the last word is written. `req_ready`=1 every cycle.
- A request is accepted on a rising edge with `req_valid` && `req_ready`. The block accepts one request per cycle with no bubbles.
- Store `funct3` codes:
  - 000 SB writes byte lane `addr[1:0]`.
  - 001 SH writes lanes {`addr[1]`,0}..+1.
  - 010 SW writes all four lanes.
  - Write data is `req_wdata` shifted to the addressed lane.
- Load `funct3` codes:
  - 000 LB and 100 LBU: byte, sign- or zero-extended.
  - 001 LH and 101 LHU: halfword, sign- or zero-extended.
  - 010 LW: full word.
- Error conditions set `rsp_err`=1:
  - illegal `funct3` (store 011..111; load 011, 110, 111);
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `req_addr` ≥ `DEPTH_BYTES`.
- On error: no memory write, `rsp_rdata`=0, response still generated.
- Stores are also acknowledged with a response: `rsp_valid`=1, `rsp_rdata`=0.
- Ordering: responses return strictly in acceptance order, exactly one per accepted request.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. The response pipeline is flushed.
- Clear sweep takes `DEPTH_BYTES/4` cycles after the first edge with `resetn`=1. `req_ready` rises in the next cycle.
- Store write lands on the acceptance edge.
- Load data is sampled from the array on the acceptance edge, then shifted through `READ_LATENCY`-1 further register stages.
- Latency: a request accepted at edge k produces `rsp_valid`=1 during the cycle after edge k+`READ_LATENCY`-1. For `READ_LATENCY`=1, that is the cycle immediately after acceptance.
- Read-after-write: a load accepted the edge after a store to the same bytes returns the new data. No forwarding is needed, since there is one request per edge.
- There is no back-pressure on the response side; the consumer must always take `rsp_valid`.
- Reset mid-operation:
  - all in-flight responses are dropped (`rsp_valid` never asserts for them);
  - the FSM returns to CLEAR;
  - the full sweep restarts from word 0.
- `resetn` low during CLEAR restarts the counter at 0.
- Inputs are ignored while `req_ready`=0.

## Test plan
- Reset release, `DEPTH_BYTES`=64 → `req_ready` stays 0 for 16 cycles, then 1. LW at 0x3C then returns 0x00000000 with `rsp_err`=0.
- Sized stores:
  - Stimulus: SW 0x11223344 @0x10; SB 0xAB @0x11; SH 0xBEEF @0x12; then LW @0x10.
  - Required: `rsp_rdata`=0xBEEFAB44.
- Extension, memory holding 0x80FF7F01 @0x20:
  - LB @0x22 → 0xFFFFFFFF; LBU @0x22 → 0x000000FF.
  - LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
- Errors:
  - LH @0x21, SW @0x22, LW @`DEPTH_BYTES`, load `funct3`=011 → each `rsp_err`=1, `rsp_rdata`=0.
  - Following LW of the target word shows it unchanged.
- Latency and throughput, `READ_LATENCY`=3, four back-to-back loads → `rsp_valid` high for four consecutive cycles starting 3 cycles after the first acceptance, data in order.
- Reset mid-flight:
  - Stimulus: `resetn` low one cycle while 2 responses are pending (`READ_LATENCY`=3).
  - Required: no `rsp_valid` for them; full clear sweep repeats; previously written data reads 0.
